// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters: predicts at fetch, learns at execute.
// Define BP_BYPASS_EN to forward a same-cycle update into the lookup result.
//
// state | meaning
// INIT  | clearing one entry per cycle, lookups ignored, updates dropped
// RUN   | table usable, lookups answered, updates applied
module branch_predictor #(
    parameter int XLEN  = 32,
    parameter int IDX_W = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    output logic            ready_o,
    input  logic            lk_valid_i,
    input  logic [XLEN-1:0] lk_pc_i,
    output logic            pred_valid_o,
    output logic            pred_hit_o,
    output logic            pred_taken_o,
    output logic [XLEN-1:0] pred_target_o,
    input  logic            upd_valid_i,
    input  logic [XLEN-1:0] upd_pc_i,
    input  logic            upd_taken_i,
    input  logic [XLEN-1:0] upd_target_i
);
    localparam int DEPTH = 1 << IDX_W;
    localparam int TAG_W = XLEN - IDX_W - 2;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]       state_q;
    logic [IDX_W-1:0] sweep_q;

    logic             valid_q  [DEPTH];
    logic [TAG_W-1:0] tag_q    [DEPTH];
    logic [XLEN-1:0]  target_q [DEPTH];
    logic [1:0]       ctr_q    [DEPTH];

    logic             run;
    logic [IDX_W-1:0] upd_idx, lk_idx;
    logic [TAG_W-1:0] upd_tag, lk_tag;
    logic             upd_fire, upd_hit;
    logic             wr_en;
    logic [1:0]       wr_ctr;
    logic [XLEN-1:0]  wr_target;

    logic             lk_entry_valid;
    logic [TAG_W-1:0] lk_entry_tag;
    logic [1:0]       lk_entry_ctr;
    logic [XLEN-1:0]  lk_entry_target;
    logic             lk_hit, lk_taken;

    logic             unused_pc_bits;

    assign unused_pc_bits = ^{lk_pc_i[1:0], upd_pc_i[1:0]};

    assign run     = (state_q == ST_RUN);
    assign ready_o = run;

    assign upd_idx = upd_pc_i[IDX_W+1:2];
    assign upd_tag = upd_pc_i[XLEN-1:IDX_W+2];
    assign lk_idx  = lk_pc_i[IDX_W+1:2];
    assign lk_tag  = lk_pc_i[XLEN-1:IDX_W+2];

    // Flush takes priority over a coincident update.
    assign upd_fire = run && upd_valid_i && !flush_i;
    assign upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    always_comb begin
        wr_en     = 1'b0;
        wr_ctr    = ctr_q[upd_idx];
        wr_target = target_q[upd_idx];
        if (upd_fire) begin
            if (upd_hit) begin
                wr_en = 1'b1;
                if (upd_taken_i) begin
                    wr_ctr    = (ctr_q[upd_idx] == 2'b11) ? 2'b11 : ctr_q[upd_idx] + 2'b01;
                    wr_target = upd_target_i;
                end else begin
                    wr_ctr = (ctr_q[upd_idx] == 2'b00) ? 2'b00 : ctr_q[upd_idx] - 2'b01;
                end
            end else if (upd_taken_i) begin
                wr_en     = 1'b1;
                wr_ctr    = 2'b10;
                wr_target = upd_target_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_INIT;
            sweep_q <= '0;
        end else if (flush_i) begin
            state_q <= ST_INIT;
            sweep_q <= '0;
        end else if (state_q == ST_INIT) begin
            sweep_q <= sweep_q + IDX_W'(1);
            if (&sweep_q) begin
                state_q <= ST_RUN;
            end
        end
    end

    // Table contents need no reset: the sweep clears them before RUN is reached.
    always_ff @(posedge clk_i) begin
        if (state_q == ST_INIT) begin
            valid_q[sweep_q] <= 1'b0;
            ctr_q[sweep_q]   <= 2'b01;
        end else if (wr_en) begin
            valid_q[upd_idx]  <= 1'b1;
            tag_q[upd_idx]    <= upd_tag;
            ctr_q[upd_idx]    <= wr_ctr;
            target_q[upd_idx] <= wr_target;
        end
    end

    always_comb begin
        lk_entry_valid  = valid_q[lk_idx];
        lk_entry_tag    = tag_q[lk_idx];
        lk_entry_ctr    = ctr_q[lk_idx];
        lk_entry_target = target_q[lk_idx];
`ifdef BP_BYPASS_EN
        if (wr_en && (upd_idx == lk_idx)) begin
            lk_entry_valid  = 1'b1;
            lk_entry_tag    = upd_tag;
            lk_entry_ctr    = wr_ctr;
            lk_entry_target = wr_target;
        end
`endif
    end

    assign lk_hit   = lk_entry_valid && (lk_entry_tag == lk_tag);
    assign lk_taken = lk_hit && lk_entry_ctr[1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pred_valid_o  <= 1'b0;
            pred_hit_o    <= 1'b0;
            pred_taken_o  <= 1'b0;
            pred_target_o <= '0;
        end else begin
            pred_valid_o  <= run && lk_valid_i;
            pred_hit_o    <= run && lk_valid_i && lk_hit;
            pred_taken_o  <= run && lk_valid_i && lk_taken;
            pred_target_o <= (run && lk_valid_i && lk_taken) ? lk_entry_target : '0;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed vector table, sweep/flush/reset
// sequences, and a randomized run against an array-based reference model.
module tb_branch_predictor;
    localparam int XLEN  = 32;
    localparam int IDX_W = 4;
    localparam int DEPTH = 16;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            flush_i;
    logic            ready_o;
    logic            lk_valid_i;
    logic [XLEN-1:0] lk_pc_i;
    logic            pred_valid_o;
    logic            pred_hit_o;
    logic            pred_taken_o;
    logic [XLEN-1:0] pred_target_o;
    logic            upd_valid_i;
    logic [XLEN-1:0] upd_pc_i;
    logic            upd_taken_i;
    logic [XLEN-1:0] upd_target_i;

    branch_predictor #(.XLEN(XLEN), .IDX_W(IDX_W)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .flush_i       (flush_i),
        .ready_o       (ready_o),
        .lk_valid_i    (lk_valid_i),
        .lk_pc_i       (lk_pc_i),
        .pred_valid_o  (pred_valid_o),
        .pred_hit_o    (pred_hit_o),
        .pred_taken_o  (pred_taken_o),
        .pred_target_o (pred_target_o),
        .upd_valid_i   (upd_valid_i),
        .upd_pc_i      (upd_pc_i),
        .upd_taken_i   (upd_taken_i),
        .upd_target_i  (upd_target_i)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utg;
        logic        lv;
        logic [31:0] lpc;
        logic        ev;
        logic        eh;
        logic        et;
        logic [31:0] etg;
    } vec_t;

    vec_t vt[21];

    // Reference model: plain per-index records, counter as an integer 0..3.
    bit          m_valid [DEPTH];
    int unsigned m_tag   [DEPTH];
    logic [31:0] m_tgt   [DEPTH];
    int          m_ctr   [DEPTH];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic uv, input logic [31:0] upc, input logic ut,
                         input logic [31:0] utg, input logic lv, input logic [31:0] lpc);
        upd_valid_i  = uv;
        upd_pc_i     = upc;
        upd_taken_i  = ut;
        upd_target_i = utg;
        lk_valid_i   = lv;
        lk_pc_i      = lpc;
    endtask

    function automatic vec_t mk(input logic uv, input logic [31:0] upc, input logic ut,
                                input logic [31:0] utg, input logic lv, input logic [31:0] lpc,
                                input logic eh, input logic et, input logic [31:0] etg);
        vec_t v;
        v.uv = uv; v.upc = upc; v.ut = ut; v.utg = utg;
        v.lv = lv; v.lpc = lpc;
        v.ev = lv; v.eh = eh; v.et = et; v.etg = etg;
        return v;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
        end
    endtask

    task automatic m_predict(input logic [31:0] pc, output bit h, output bit t, output logic [31:0] tg);
        int idx;
        idx = int'((pc / 4) % DEPTH);
        h   = m_valid[idx] && (m_tag[idx] == pc / 64);
        t   = h && (m_ctr[idx] >= 2);
        tg  = t ? m_tgt[idx] : 32'h0;
    endtask

    task automatic m_update(input logic [31:0] pc, input bit taken, input logic [31:0] tg);
        int idx;
        bit h;
        idx = int'((pc / 4) % DEPTH);
        h   = m_valid[idx] && (m_tag[idx] == pc / 64);
        if (h) begin
            if (taken) begin
                m_ctr[idx] = (m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3;
                m_tgt[idx] = tg;
            end else begin
                m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
            end
        end else if (taken) begin
            m_valid[idx] = 1'b1;
            m_tag[idx]   = pc / 64;
            m_tgt[idx]   = tg;
            m_ctr[idx]   = 2;
        end
    endtask

    // Counts cycles until ready_o rises; lookups presented throughout must stay unanswered.
    task automatic wait_sweep(input string name);
        int  n;
        bit  done;
        n    = 0;
        done = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h100);
        for (int i = 1; i <= 40 && !done; i++) begin
            step();
            chk({name, "_pvalid"}, 32'(pred_valid_o), 32'h0);
            if (ready_o) begin
                done = 1'b1;
                n    = i;
            end
        end
        chk({name, "_cycles"}, 32'(n), 32'd16);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] tag;
        case ($urandom_range(0, 3))
            0:       tag = 32'h0;
            1:       tag = 32'h1;
            2:       tag = 32'h3ff_ffff;
            default: tag = 32'h0ab_cdef;
        endcase
        return (tag << 6) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
    endfunction

    initial begin
        bit          mh, mt;
        logic [31:0] mtg;
        logic        uv, ut, lv;
        logic [31:0] upc, utg, lpc;

        rst_i   = 1'b1;
        flush_i = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        step();
        step();
        chk("reset_ready", 32'(ready_o), 32'h0);
        chk("reset_pvalid", 32'(pred_valid_o), 32'h0);
        chk("reset_target", pred_target_o, 32'h0);

        // Reset released, then reasserted mid-sweep.
        rst_i = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h100);
        for (int i = 0; i < 5; i++) step();
        chk("midsweep_ready", 32'(ready_o), 32'h0);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        wait_sweep("reset_sweep");

        vt[0]  = mk(1, 32'h100,  1, 32'h200, 0, 32'h0,    0, 0, 32'h0);
        vt[1]  = mk(0, 32'h0,    0, 32'h0,   1, 32'h100,  1, 1, 32'h200);
        vt[2]  = mk(0, 32'h0,    0, 32'h0,   1, 32'h104,  0, 0, 32'h0);
        vt[3]  = mk(1, 32'h100,  0, 32'h0,   0, 32'h0,    0, 0, 32'h0);
        vt[4]  = mk(0, 32'h0,    0, 32'h0,   1, 32'h100,  1, 0, 32'h0);
        vt[5]  = mk(1, 32'h100,  0, 32'h0,   0, 32'h0,    0, 0, 32'h0);
        vt[6]  = mk(1, 32'h100,  0, 32'h0,   0, 32'h0,    0, 0, 32'h0);
        vt[7]  = mk(1, 32'h100,  1, 32'h240, 0, 32'h0,    0, 0, 32'h0);
        vt[8]  = mk(0, 32'h0,    0, 32'h0,   1, 32'h100,  1, 0, 32'h0);
        vt[9]  = mk(1, 32'h100,  1, 32'h240, 0, 32'h0,    0, 0, 32'h0);
        vt[10] = mk(0, 32'h0,    0, 32'h0,   1, 32'h100,  1, 1, 32'h240);
        vt[11] = mk(1, 32'h1100, 1, 32'h300, 0, 32'h0,    0, 0, 32'h0);
        vt[12] = mk(0, 32'h0,    0, 32'h0,   1, 32'h100,  0, 0, 32'h0);
        vt[13] = mk(0, 32'h0,    0, 32'h0,   1, 32'h1100, 1, 1, 32'h300);
        vt[14] = mk(1, 32'h100,  1, 32'h400, 0, 32'h0,    0, 0, 32'h0);
        vt[15] = mk(1, 32'h100,  0, 32'h0,   0, 32'h0,    0, 0, 32'h0);
`ifdef BP_BYPASS_EN
        vt[16] = mk(1, 32'h100,  1, 32'h500, 1, 32'h100,  1, 1, 32'h500);
`else
        vt[16] = mk(1, 32'h100,  1, 32'h500, 1, 32'h100,  1, 0, 32'h0);
`endif
        vt[17] = mk(0, 32'h0,    0, 32'h0,   1, 32'h100,  1, 1, 32'h500);
        vt[18] = mk(1, 32'h144,  0, 32'h0,   0, 32'h0,    0, 0, 32'h0);
        vt[19] = mk(0, 32'h0,    0, 32'h0,   1, 32'h144,  0, 0, 32'h0);
        vt[20] = mk(0, 32'h0,    0, 32'h0,   1, 32'h103,  1, 1, 32'h500);

        for (int i = 0; i < 21; i++) begin
            drive(vt[i].uv, vt[i].upc, vt[i].ut, vt[i].utg, vt[i].lv, vt[i].lpc);
            step();
            chk($sformatf("vec%0d_valid", i), 32'(pred_valid_o), 32'(vt[i].ev));
            if (vt[i].lv) begin
                chk($sformatf("vec%0d_hit", i), 32'(pred_hit_o), 32'(vt[i].eh));
                chk($sformatf("vec%0d_taken", i), 32'(pred_taken_o), 32'(vt[i].et));
                chk($sformatf("vec%0d_target", i), pred_target_o, vt[i].etg);
            end
        end

        // Flush in RUN together with an update: update dropped, table swept.
        drive(1'b1, 32'h200, 1'b1, 32'h900, 1'b0, 32'h0);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        chk("flush_ready", 32'(ready_o), 32'h0);
        wait_sweep("flush_sweep");
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h100);
        step();
        chk("flush_miss_100", 32'(pred_hit_o), 32'h0);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h1100);
        step();
        chk("flush_miss_1100", 32'(pred_hit_o), 32'h0);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h200);
        step();
        chk("flush_dropped_upd", 32'(pred_hit_o), 32'h0);

        // Flush arriving at sweep index 7 restarts the full sweep.
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        for (int i = 0; i < 7; i++) step();
        chk("flush7_ready", 32'(ready_o), 32'h0);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        wait_sweep("flush7_sweep");

        m_clear();
        for (int c = 0; c < 800; c++) begin
            uv  = 1'($urandom_range(0, 1));
            upc = rand_pc();
            ut  = 1'($urandom_range(0, 1));
            utg = $urandom;
            lv  = 1'($urandom_range(0, 3) != 0);
            lpc = ($urandom_range(0, 2) == 0) ? upc : rand_pc();
`ifdef BP_BYPASS_EN
            if (uv) m_update(upc, ut, utg);
            m_predict(lpc, mh, mt, mtg);
`else
            m_predict(lpc, mh, mt, mtg);
            if (uv) m_update(upc, ut, utg);
`endif
            drive(uv, upc, ut, utg, lv, lpc);
            step();
            chk("rand_valid", 32'(pred_valid_o), 32'(lv));
            if (lv) begin
                chk("rand_hit", 32'(pred_hit_o), 32'(mh));
                chk("rand_taken", 32'(pred_taken_o), 32'(mt));
                chk("rand_target", pred_target_o, mtg);
            end
        end

        // Reset mid-lookup: outputs must clear before the next edge.
        drive(1'b1, 32'h100, 1'b1, 32'h700, 1'b0, 32'h0);
        step();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h100);
        step();
        chk("prerst_pvalid", 32'(pred_valid_o), 32'h1);
        chk("prerst_taken", 32'(pred_taken_o), 32'h1);
        #2;
        rst_i = 1'b1;
        #1;
        chk("rst_async_pvalid", 32'(pred_valid_o), 32'h0);
        chk("rst_async_taken", 32'(pred_taken_o), 32'h0);
        chk("rst_async_target", pred_target_o, 32'h0);
        chk("rst_async_ready", 32'(ready_o), 32'h0);
        step();
        chk("rst_hold_pvalid", 32'(pred_valid_o), 32'h0);
        rst_i = 1'b0;
        wait_sweep("rst_sweep");
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h100);
        step();
        chk("rst_miss_valid", 32'(pred_valid_o), 32'h1);
        chk("rst_miss_hit", 32'(pred_hit_o), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
